// File: rtl/cpu_pkg.sv
// Shared CPU definitions.
//   PC_OP_W : width of the program-counter operation code
//   pc_op_t : program-counter operation encoding (codes 6-7 are unused and
//             decode as INC)
package cpu_pkg;

  localparam int PC_OP_W = 3;

  typedef enum logic [PC_OP_W-1:0] {
    INC  = 3'd0,
    JMP  = 3'd1,
    BR   = 3'd2,
    CALL = 3'd3,
    RET  = 3'd4,
    HOLD = 3'd5
  } pc_op_t;

endpackage

// File: rtl/cpu_pc_stack_if.sv
// Control-unit <-> program-counter bus.
//   master : control unit side (drives EN/OP/ADDR/OFFSET, observes status)
//   slave  : cpu_pc_stack side
// Signals:
//   EN      advance enable (0 = stall)
//   OP      pc_op_t operation code
//   ADDR    absolute target for JMP/CALL
//   OFFSET  two's-complement displacement for BR
//   PC_OUT  current program counter
//   SP      valid return-stack entries, 0..DEPTH
//   FULL    SP == DEPTH
//   EMPTY   SP == 0
//   OVF     sticky stack overflow
//   UNF     sticky stack underflow
interface cpu_pc_stack_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  import cpu_pkg::*;

  localparam int SPW = $clog2(DEPTH) + 1;

  logic               EN;
  logic [PC_OP_W-1:0] OP;
  logic [WIDTH-1:0]   ADDR;
  logic [WIDTH-1:0]   OFFSET;
  logic [WIDTH-1:0]   PC_OUT;
  logic [SPW-1:0]     SP;
  logic               FULL;
  logic               EMPTY;
  logic               OVF;
  logic               UNF;

  modport master (
    output EN, OP, ADDR, OFFSET,
    input  PC_OUT, SP, FULL, EMPTY, OVF, UNF
  );

  modport slave (
    input  EN, OP, ADDR, OFFSET,
    output PC_OUT, SP, FULL, EMPTY, OVF, UNF
  );

endinterface

// File: rtl/cpu_ras.sv
// Return-address LIFO.
//   CLK, RST_N : clock, synchronous active-low reset (clears SP only)
//   PUSH, DIN  : push DIN; ignored when FULL
//   POP        : drop the top entry; ignored when EMPTY
//   TOP        : entry at SP-1 (don't-care when EMPTY)
//   SP         : number of valid entries, 0..DEPTH
//   FULL/EMPTY : decoded from SP
module cpu_ras #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int SPW  = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             PUSH,
  input  logic             POP,
  input  logic [WIDTH-1:0] DIN,
  output logic [WIDTH-1:0] TOP,
  output logic [SPW-1:0]   SP,
  output logic             FULL,
  output logic             EMPTY
);

  localparam int IW = SPW - 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [SPW-1:0]   r_sp;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic [IW-1:0]    w_wr_idx;
  logic [IW-1:0]    w_rd_idx;

  assign FULL  = (r_sp == SPW'(DEPTH));
  assign EMPTY = (r_sp == '0);
  assign SP    = r_sp;

  // Push has priority; the PC decode never asserts both in one cycle.
  assign w_push_ok = PUSH && !FULL;
  assign w_pop_ok  = POP && !EMPTY && !PUSH;

  // DEPTH is a power of two, so the low bits of SP address the array
  // directly. A write at index SP is read back at SP-1 on the next cycle,
  // so no bypass is needed for CALL followed by RET.
  assign w_wr_idx = r_sp[IW-1:0];
  assign w_rd_idx = w_wr_idx - IW'(1);
  assign TOP      = r_mem[w_rd_idx];

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_sp <= '0;
    end else if (w_push_ok) begin
      r_sp <= r_sp + SPW'(1);
    end else if (w_pop_ok) begin
      r_sp <= r_sp - SPW'(1);
    end
  end

  // Contents are intentionally not reset; only entries below SP matter.
  always_ff @(posedge CLK) begin
    if (w_push_ok) begin
      r_mem[w_wr_idx] <= DIN;
    end
  end

endmodule

// File: rtl/cpu_pc_stack.sv
// Program counter with hardware return-address stack.
//   CLK, RST_N : clock, synchronous active-low reset
//   bus        : cpu_pc_stack_if slave (EN/OP/ADDR/OFFSET in,
//                PC_OUT/SP/FULL/EMPTY/OVF/UNF out)
// All outputs are registers or decoded from registers only; every op
// completes in one cycle and is visible on the following cycle.
module cpu_pc_stack
  import cpu_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic           CLK,
  input  logic           RST_N,
  cpu_pc_stack_if.slave  bus
);

  localparam int SPW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_pc;
  logic             r_ovf;
  logic             r_unf;

  logic [WIDTH-1:0] w_pc_nxt;
  logic [WIDTH-1:0] w_pc_inc;
  logic [WIDTH-1:0] w_top;
  logic [SPW-1:0]   w_sp;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_ovf_set;
  logic             w_unf_set;

  // Natural WIDTH-bit wrap gives the modulo-2^WIDTH arithmetic.
  assign w_pc_inc = r_pc + WIDTH'(1);

  always_comb begin
    w_pc_nxt  = r_pc;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_ovf_set = 1'b0;
    w_unf_set = 1'b0;
    if (bus.EN) begin
      case (bus.OP)
        JMP:  w_pc_nxt = bus.ADDR;
        BR:   w_pc_nxt = r_pc + bus.OFFSET;
        CALL: begin
          // A refused call neither pushes nor jumps.
          if (w_full) begin
            w_ovf_set = 1'b1;
          end else begin
            w_push   = 1'b1;
            w_pc_nxt = bus.ADDR;
          end
        end
        RET: begin
          if (w_empty) begin
            w_unf_set = 1'b1;
          end else begin
            w_pop    = 1'b1;
            w_pc_nxt = w_top;
          end
        end
        HOLD:    w_pc_nxt = r_pc;
        default: w_pc_nxt = w_pc_inc;  // INC and reserved codes
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_pc  <= RESET_VEC;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_pc  <= w_pc_nxt;
      r_ovf <= r_ovf | w_ovf_set;
      r_unf <= r_unf | w_unf_set;
    end
  end

  cpu_ras #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ras (
    .CLK   (CLK),
    .RST_N (RST_N),
    .PUSH  (w_push),
    .POP   (w_pop),
    .DIN   (w_pc_inc),
    .TOP   (w_top),
    .SP    (w_sp),
    .FULL  (w_full),
    .EMPTY (w_empty)
  );

  assign bus.PC_OUT = r_pc;
  assign bus.SP     = w_sp;
  assign bus.FULL   = w_full;
  assign bus.EMPTY  = w_empty;
  assign bus.OVF    = r_ovf;
  assign bus.UNF    = r_unf;

endmodule

// File: tb/tb_cpu_pc_stack.sv
// Self-checking bench for cpu_pc_stack: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// queue-based reference model.
module tb_cpu_pc_stack;

  localparam int         WIDTH = 8;
  localparam int         DEPTH = 4;
  localparam logic [7:0] RV    = 8'h10;

  logic CLK;
  logic RST_N;

  cpu_pc_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  cpu_pc_stack #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .RESET_VEC (RV)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  // Reference model: PC as an 8-bit value, stack as a queue.
  logic [7:0] m_pc;
  logic [7:0] m_stk[$];
  bit         m_ovf;
  bit         m_unf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model(input bit rst_n, input bit en, input logic [2:0] op,
                                input logic [7:0] a, input logic [7:0] off);
    if (!rst_n) begin
      m_pc = RV;
      m_stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (en) begin
      case (op)
        3'd1: m_pc = a;
        3'd2: m_pc = m_pc + off;
        3'd3: begin
          if (m_stk.size() == DEPTH) m_ovf = 1'b1;
          else begin
            m_stk.push_back(m_pc + 8'd1);
            m_pc = a;
          end
        end
        3'd4: begin
          if (m_stk.size() == 0) m_unf = 1'b1;
          else m_pc = m_stk.pop_back();
        end
        3'd5: ;
        default: m_pc = m_pc + 8'd1;
      endcase
    end
  endfunction

  // Apply one cycle of stimulus; returns #1 after the sampling edge.
  task automatic step(input bit rst_n, input bit en, input logic [2:0] op,
                      input logic [7:0] a, input logic [7:0] off);
    RST_N      = rst_n;
    bus.EN     = en;
    bus.OP     = op;
    bus.ADDR   = a;
    bus.OFFSET = off;
    @(posedge CLK);
    model(rst_n, en, op, a, off);
    #1;
  endtask

  // Single compare process: DUT vs model on every falling edge.
  always @(negedge CLK) begin
    if (chk_on) begin
      check("pc",    32'(bus.PC_OUT), 32'(m_pc));
      check("sp",    32'(bus.SP),     32'(m_stk.size()));
      check("full",  32'(bus.FULL),   32'(m_stk.size() == DEPTH));
      check("empty", 32'(bus.EMPTY),  32'(m_stk.size() == 0));
      check("ovf",   32'(bus.OVF),    32'(m_ovf));
      check("unf",   32'(bus.UNF),    32'(m_unf));
    end
  end

  initial begin
    RST_N = 1'b0; bus.EN = 1'b0; bus.OP = '0; bus.ADDR = '0; bus.OFFSET = '0;
    m_pc = RV; m_ovf = 1'b0; m_unf = 1'b0;

    // Reset state and sequential increment
    step(0, 0, 0, 0, 0);
    chk_on = 1'b1;
    check("rst_pc",    32'(bus.PC_OUT), 32'h10);
    check("rst_sp",    32'(bus.SP),     0);
    check("rst_empty", 32'(bus.EMPTY),  1);
    check("rst_full",  32'(bus.FULL),   0);
    check("rst_ovf",   32'(bus.OVF),    0);
    check("rst_unf",   32'(bus.UNF),    0);
    step(1, 1, 0, 0, 0); check("inc1", 32'(bus.PC_OUT), 32'h11);
    step(1, 1, 0, 0, 0); check("inc2", 32'(bus.PC_OUT), 32'h12);
    step(1, 1, 7, 0, 0); check("inc3_rsvd", 32'(bus.PC_OUT), 32'h13);
    check("inc_sp", 32'(bus.SP), 0);

    // Wrap-around
    step(1, 1, 1, 8'hFE, 0);
    step(1, 1, 0, 0, 0); check("wrap_ff", 32'(bus.PC_OUT), 32'hFF);
    step(1, 1, 0, 0, 0); check("wrap_00", 32'(bus.PC_OUT), 32'h00);
    step(1, 1, 1, 8'h02, 0);
    step(1, 1, 2, 0, 8'hFC); check("br_neg", 32'(bus.PC_OUT), 32'hFE);
    step(1, 1, 5, 8'h77, 8'h11); check("hold", 32'(bus.PC_OUT), 32'hFE);

    // Nested call/return, back-to-back
    step(1, 1, 1, 8'h20, 0);
    step(1, 1, 3, 8'h40, 0); check("call1_pc", 32'(bus.PC_OUT), 32'h40); check("call1_sp", 32'(bus.SP), 1);
    step(1, 1, 3, 8'h60, 0); check("call2_pc", 32'(bus.PC_OUT), 32'h60); check("call2_sp", 32'(bus.SP), 2);
    step(1, 1, 4, 0, 0);     check("ret1_pc",  32'(bus.PC_OUT), 32'h41); check("ret1_sp",  32'(bus.SP), 1);
    step(1, 1, 4, 0, 0);     check("ret2_pc",  32'(bus.PC_OUT), 32'h21); check("ret2_sp",  32'(bus.SP), 0);

    // Overflow
    step(0, 0, 0, 0, 0);
    step(1, 1, 3, 8'hA0, 0);
    step(1, 1, 3, 8'hB0, 0);
    step(1, 1, 3, 8'hC0, 0);
    step(1, 1, 3, 8'hD0, 0); check("fill_full", 32'(bus.FULL), 1);
    step(1, 1, 3, 8'h99, 0);
    check("ovf_pc",  32'(bus.PC_OUT), 32'hD0);
    check("ovf_sp",  32'(bus.SP),     DEPTH);
    check("ovf_set", 32'(bus.OVF),    1);
    step(1, 1, 4, 0, 0);
    check("ovf_ret_pc",  32'(bus.PC_OUT), 32'hC1);
    check("ovf_ret_sp",  32'(bus.SP),     3);
    check("ovf_sticky",  32'(bus.OVF),    1);

    // Underflow
    step(0, 0, 0, 0, 0);
    step(1, 1, 4, 0, 0);
    check("unf_pc",  32'(bus.PC_OUT), 32'h10);
    check("unf_set", 32'(bus.UNF),    1);
    check("unf_sp",  32'(bus.SP),     0);
    step(1, 1, 1, 8'h33, 0);
    check("unf_jmp_pc", 32'(bus.PC_OUT), 32'h33);
    check("unf_sticky", 32'(bus.UNF),    1);

    // Stall, then reset wins over a call
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 3, 8'h50, 0);
      check("stall_pc", 32'(bus.PC_OUT), 32'h33);
      check("stall_sp", 32'(bus.SP),     0);
    end
    step(0, 1, 3, 8'h50, 0);
    check("rstwin_pc",  32'(bus.PC_OUT), 32'h10);
    check("rstwin_sp",  32'(bus.SP),     0);
    check("rstwin_unf", 32'(bus.UNF),    0);
    check("rstwin_ovf", 32'(bus.OVF),    0);

    // Randomized traffic, biased toward stack operations
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] op;
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 3)      op = 3'd3;
      else if (sel < 6) op = 3'd4;
      else              op = 3'($urandom_range(0, 7));
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 7) != 0), op,
           8'($urandom), 8'($urandom));
    end

    @(negedge CLK);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
